// File: rtl/signmag_to_twos.sv
// signmag_to_twos: rebuilds a two's-complement value from sign + magnitude.
// Negative inputs are negated nibble-serially (invert, then ripple a +1
// through one NIB-bit slice per cycle), so a single small incrementer is used.
// One transaction in flight, valid/ready on both sides.
module signmag_to_twos #(
  parameter int WIDTH = 16,
  parameter int NIB   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign,
  input  logic [WIDTH-1:0] mag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value,
  output logic             ovf
);

  localparam int NSTEPS = WIDTH / NIB;
  localparam int SW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  typedef enum logic [1:0] {IDLE, NEG, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] value_r;
  logic             ovf_r;
  logic             carry;
  logic [SW-1:0]    step;
  logic             accept;
  logic             last_step;
  logic [NIB:0]     nib_sum;

  // NIB-bit increment slice; MSB of the result is the carry-out.
  function automatic logic [NIB:0] nib_inc(input logic [NIB-1:0] n, input logic c);
    return {1'b0, n} + {{NIB{1'b0}}, c};
  endfunction

  // Signed range check: a positive magnitude must fit below 2^(WIDTH-1),
  // a negative one may reach exactly 2^(WIDTH-1).
  function automatic logic ovf_calc(input logic s, input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] lim;
    lim = {1'b1, {(WIDTH-1){1'b0}}};
    return s ? (m > lim) : m[WIDTH-1];
  endfunction

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign value     = value_r;
  assign ovf       = ovf_r;
  assign accept    = in_valid && in_ready;
  assign last_step = (step == SW'(NSTEPS - 1));
  assign nib_sum   = nib_inc(value_r[step*NIB +: NIB], carry);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed NSTEPS cycles in NEG regardless of data.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = sign ? NEG : DONE;
      NEG:     if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture on accept, then ripple the +1 one nibble per NEG cycle.
  // Outside NEG the registers hold, keeping value/ovf stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= '0;
      ovf_r   <= 1'b0;
      carry   <= 1'b0;
      step    <= '0;
    end else if (accept) begin
      value_r <= sign ? ~mag : mag;
      ovf_r   <= ovf_calc(sign, mag);
      carry   <= sign;
      step    <= '0;
    end else if (state == NEG) begin
      value_r[step*NIB +: NIB] <= nib_sum[NIB-1:0];
      carry                    <= nib_sum[NIB];
      step                     <= step + 1'b1;
    end
  end

endmodule

// File: tb/tb_signmag_to_twos.sv
// Directed bench for signmag_to_twos with hand-computed expected values.
module tb_signmag_to_twos;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [15:0] mag;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] value;
  logic        ovf;

  int n_asserts = 0;
  int n_fails   = 0;

  signmag_to_twos #(.WIDTH(16), .NIB(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .mag       (mag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .value     (value),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One transaction: accept, measure latency, check result, optionally hold
  // out_ready low for 'hold' cycles, optionally wiggle in_valid during NEG.
  task automatic run(input string tag, input logic s, input logic [15:0] m,
                     input logic [15:0] expv, input logic expo, input int explat,
                     input int hold, input bit noise);
    int n;
    int lat;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, "_in_ready_before"}, in_ready, 1);
    out_ready = (hold == 0);
    sign      = s;
    mag       = m;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    sign     = 1'b0;
    mag      = 16'h0;
    lat      = 1;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        chk({tag, "_in_ready_neg"}, in_ready, 0);
        in_valid = lat[0];
        mag      = 16'h5555;
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, lat, explat);
    chk({tag, "_value"}, value, expv);
    chk({tag, "_ovf"}, ovf, expo);
    chk({tag, "_in_ready_done"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_value"}, value, expv);
      chk({tag, "_hold_ovf"}, ovf, expo);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    chk({tag, "_out_valid_after"}, out_valid, 0);
    chk({tag, "_in_ready_after"}, in_ready, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    sign      = 1'b0;
    mag       = 16'h0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_value", value, 0);
    chk("rst_ovf", ovf, 0);
    rst_n = 1'b1;
    tick();

    run("pos_1234",   1'b0, 16'h1234, 16'h1234, 1'b0, 1, 0, 0);
    run("neg_0001",   1'b1, 16'h0001, 16'hFFFF, 1'b0, 5, 0, 0);
    run("neg_00f0",   1'b1, 16'h00F0, 16'hFF10, 1'b0, 5, 0, 0);
    run("neg_8000",   1'b1, 16'h8000, 16'h8000, 1'b0, 5, 0, 0);
    run("neg_8001",   1'b1, 16'h8001, 16'h7FFF, 1'b1, 5, 0, 0);
    run("pos_8000",   1'b0, 16'h8000, 16'h8000, 1'b1, 1, 0, 0);
    run("neg_zero",   1'b1, 16'h0000, 16'h0000, 1'b0, 5, 0, 0);
    run("backpress",  1'b1, 16'h0003, 16'hFFFD, 1'b0, 5, 6, 0);
    run("ignored_in", 1'b1, 16'h0002, 16'hFFFE, 1'b0, 5, 0, 1);

    // Reset during the second NEG cycle, asserted between clock edges.
    sign     = 1'b1;
    mag      = 16'h9000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("mid_in_ready_neg", in_ready, 0);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_value", value, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    #2;
    rst_n = 1'b1;
    tick();
    run("after_rst", 1'b1, 16'h0010, 16'hFFF0, 1'b0, 5, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/signmag_to_twos.md
Name: signmag_to_twos

Overview:
Sequential inverse of the absolute-value path. It takes a sign bit plus an unsigned magnitude and rebuilds the two's-complement signed value. Negation is done nibble-serially, one CLA-width nibble per cycle, so only one 4-bit increment slice is needed. The block sits downstream of magnitude-domain arithmetic and uses a valid/ready handshake on both sides, one transaction in flight.

Parameters:
WIDTH, 16, data width in bits; must be a multiple of NIB
NIB, 4, bits processed per negation cycle (one CLA group)
NSTEPS, WIDTH/NIB (derived localparam), negation cycles per transaction

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input transaction present
in_ready  output  1  block can accept input
sign  input  1  1 = negative, 0 = positive
mag  input  WIDTH  unsigned magnitude
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
value  output  WIDTH  two's-complement result
ovf  output  1  magnitude not representable as signed WIDTH-bit

Behaviour:
- Reset state (rst_n low, asynchronous): state IDLE, in_ready=1, out_valid=0, value=0, ovf=0, carry=0, step counter=0.
- Reset is honoured at any point, including mid-NEG or while DONE is waiting on out_ready. The partial result is discarded.
- FSM states: IDLE, NEG, DONE.
- Outputs per state: in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept condition: in_valid && in_ready, at edge E0.
  - sign=0: value<=mag, go to DONE. out_valid is visible right after E0 (latency 1).
  - sign=1: value<=~mag, carry<=1, step<=0, go to NEG.
- NEG state, each edge:
  - nibble[step] <= nibble[step] + carry (NIB-bit add).
  - carry <= carry-out of that add.
  - step <= step+1.
  - After processing step NSTEPS-1, go to DONE.
  - out_valid is visible after E0+NSTEPS (latency 1+NSTEPS = 5 at defaults). Latency is fixed and does not depend on data; there is no early exit.
- Final carry-out is discarded. Negative zero (sign=1, mag=0) yields value=0, ovf=0.
- ovf is computed combinationally from sign/mag at acceptance and registered at E0. It is held through NEG and DONE.
  - sign=0: ovf = mag[WIDTH-1].
  - sign=1: ovf = (mag > 2^(WIDTH-1)).
- value is still produced as the mod-2^WIDTH result when ovf=1.
- DONE state: value and ovf are held stable while out_valid=1 and out_ready=0. On out_valid && out_ready, go to IDLE. out_valid drops on the next cycle.
- No bypass: a new input cannot be accepted in the same cycle as the output handshake. Throughput is one result per 2 cycles (positive) or per 2+NSTEPS cycles (negative), given out_ready=1.
- in_valid while not IDLE is ignored; the source must hold it. sign and mag are sampled only at acceptance and may change freely afterwards.
- value is not guaranteed meaningful during NEG; consumers use it only when out_valid=1.

Test Plan:
- Positive passthrough: sign=0, mag=0x1234, out_ready=1 -> out_valid high 1 cycle after accept, value=0x1234, ovf=0, in_ready back high the following cycle.
- Basic negate: sign=1, mag=0x0001 -> out_valid exactly 5 cycles after accept, value=0xFFFF, ovf=0. Also sign=1, mag=0x00F0 -> value=0xFF10, checking carry ripple across nibbles.
- Boundary values:
  - sign=1, mag=0x8000 -> value=0x8000, ovf=0.
  - sign=1, mag=0x8001 -> value=0x7FFF, ovf=1.
  - sign=0, mag=0x8000 -> value=0x8000, ovf=1.
  - sign=1, mag=0x0000 -> value=0x0000, ovf=0.
- Backpressure: sign=1, mag=0x0003, out_ready=0 for 6 cycles after out_valid -> value=0xFFFD and ovf held stable, in_ready=0 throughout. Raising out_ready completes the handshake and the block returns to IDLE.
- Ignored input: during NEG, toggle in_valid with mag=0x5555 -> not accepted, result unaffected, in_ready stays 0.
- Reset mid-operation: assert rst_n=0 asynchronously (between clock edges) at the 2nd NEG cycle -> out_valid=0, value=0, ovf=0, in_ready=1 immediately. After release, a new sign=1, mag=0x0010 transaction yields 0xFFF0 with normal 5-cycle latency.
